// File: rtl/anacron_io_pkg.sv
// ============================================================================
// anacron_io_pkg : opcodes, command FSM states and UART bit phases.
// Rev 1.0
// ============================================================================
`default_nettype none

package anacron_io_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] RESP_ACK  = 8'h01;

   typedef enum logic [1:0] {
      CMD_IDLE      = 2'd0,
      CMD_WAIT_DATA = 2'd1,
      CMD_RESP      = 2'd2
   } cmd_state_e;

   typedef enum logic [2:0] {
      PH_IDLE      = 3'd0,
      PH_LEAD      = 3'd1,
      PH_START     = 3'd2,
      PH_DATA      = 3'd3,
      PH_PARITY    = 3'd4,
      PH_STOP      = 3'd5,
      PH_TAIL      = 3'd6,
      PH_WAIT_HIGH = 3'd7
   } uart_phase_e;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/anacron_uart_bitclk.sv
// ============================================================================
// anacron_uart_bitclk : bit-period counter with restart, mid-bit and bit-end strobes.
// Rev 1.0
// ============================================================================
`default_nettype none

module anacron_uart_bitclk
   import anacron_io_pkg::*;
#(
   parameter int BIT_DIV = 87
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic mid_o,
   output logic bit_o
);

   localparam int CNT_W = $clog2(BIT_DIV);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_DIV - 1);
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(BIT_DIV / 2 - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Restart lands the count at zero on the next cycle, so the mid strobe
   // fires BIT_DIV/2 cycles and the bit strobe BIT_DIV cycles after restart.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || (cnt_q == LAST_CNT)) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign mid_o = (cnt_q == MID_CNT);
   assign bit_o = (cnt_q == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/anacron_io_top.sv
// ============================================================================
// anacron_io_top : UART command interpreter driving 8 GPIO outputs, reading 8 inputs.
// Build option: ANACRON_PARITY_EN selects 8E1 framing instead of 8N1.  Rev 1.0
// ============================================================================
`default_nettype none

module anacron_io_top
   import anacron_io_pkg::*;
#(
   parameter int BIT_DIV     = 87,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] input_pins,
   output logic [7:0] output_pins,
   input  logic       rxd,
   output logic       txd,
   input  logic       cts,
   output logic       rts,
   output logic       n_tx_en
);

   logic [SYNC_STAGES-1:0] rxd_sync_q, cts_sync_q;
   logic [7:0]             pins_sync_q [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_sync_q <= '1;
         cts_sync_q <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) pins_sync_q[i] <= '0;
      end else begin
         rxd_sync_q[0]  <= rxd;
         cts_sync_q[0]  <= cts;
         pins_sync_q[0] <= input_pins;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rxd_sync_q[i]  <= rxd_sync_q[i-1];
            cts_sync_q[i]  <= cts_sync_q[i-1];
            pins_sync_q[i] <= pins_sync_q[i-1];
         end
      end
   end

   logic       rxd_s, cts_s;
   logic [7:0] pins_s;
   assign rxd_s  = rxd_sync_q[SYNC_STAGES-1];
   assign cts_s  = cts_sync_q[SYNC_STAGES-1];
   assign pins_s = pins_sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------ receiver
   uart_phase_e rx_phase_q, rx_phase_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        rx_prev_q;
   logic        rx_restart, rx_mid, rx_bit, rx_done;
`ifdef ANACRON_PARITY_EN
   logic        rx_par_ok_q, rx_par_ok_d;
`endif

   anacron_uart_bitclk #(.BIT_DIV(BIT_DIV)) u_rx_bitclk (
      .clk       (clk),
      .rst       (rst),
      .restart_i (rx_restart),
      .mid_o     (rx_mid),
      .bit_o     (rx_bit)
   );

   always_comb begin
      rx_phase_d = rx_phase_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_restart = 1'b0;
      rx_done    = 1'b0;
`ifdef ANACRON_PARITY_EN
      rx_par_ok_d = rx_par_ok_q;
`endif
      case (rx_phase_q)
         PH_IDLE: begin
            if (rx_prev_q && !rxd_s) begin
               rx_phase_d = PH_START;
               rx_restart = 1'b1;
            end
         end
         PH_START: begin
            // Re-aligning at mid start bit puts every later bit strobe mid-bit.
            if (rx_mid) begin
               if (rxd_s) begin
                  rx_phase_d = PH_IDLE;
               end else begin
                  rx_phase_d = PH_DATA;
                  rx_bit_d   = 3'd0;
                  rx_restart = 1'b1;
               end
            end
         end
         PH_DATA: begin
            if (rx_bit) begin
               rx_sh_d  = {rxd_s, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
`ifdef ANACRON_PARITY_EN
               if (rx_bit_q == 3'd7) rx_phase_d = PH_PARITY;
`else
               if (rx_bit_q == 3'd7) rx_phase_d = PH_STOP;
`endif
            end
         end
`ifdef ANACRON_PARITY_EN
         PH_PARITY: begin
            if (rx_bit) begin
               rx_par_ok_d = (rxd_s == even_parity(rx_sh_q));
               rx_phase_d  = PH_STOP;
            end
         end
`endif
         PH_STOP: begin
            if (rx_bit) begin
`ifdef ANACRON_PARITY_EN
               if (rxd_s && rx_par_ok_q) begin
`else
               if (rxd_s) begin
`endif
                  rx_done    = 1'b1;
                  rx_phase_d = PH_IDLE;
               end else begin
                  rx_phase_d = PH_WAIT_HIGH;
               end
            end
         end
         PH_WAIT_HIGH: begin
            if (rxd_s) rx_phase_d = PH_IDLE;
         end
         default: rx_phase_d = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_phase_q <= PH_IDLE;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_prev_q  <= 1'b1;
`ifdef ANACRON_PARITY_EN
         rx_par_ok_q <= 1'b0;
`endif
      end else begin
         rx_phase_q <= rx_phase_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_prev_q  <= rxd_s;
`ifdef ANACRON_PARITY_EN
         rx_par_ok_q <= rx_par_ok_d;
`endif
      end
   end

   // ------------------------------------------- holding register + command FSM
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   cmd_state_e cmd_q, cmd_d;
   logic [7:0] resp_q, resp_d;
   logic [7:0] out_q, out_d;
   logic       rts_q, rts_d;
   logic       consume, tx_accept;
   uart_phase_e tx_phase_q, tx_phase_d;

   assign consume   = hold_full_q && ((cmd_q == CMD_IDLE) || (cmd_q == CMD_WAIT_DATA));
   assign tx_accept = (cmd_q == CMD_RESP) && (tx_phase_q == PH_IDLE) && cts_s;

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (consume) begin
         hold_full_d = 1'b0;
      end else if (rx_done && !hold_full_q) begin
         hold_d      = rx_sh_q;
         hold_full_d = 1'b1;
      end
   end

   always_comb begin
      cmd_d  = cmd_q;
      resp_d = resp_q;
      out_d  = out_q;
      case (cmd_q)
         CMD_IDLE: begin
            if (hold_full_q) begin
               if (hold_q == CMD_WRITE) begin
                  cmd_d = CMD_WAIT_DATA;
               end else begin
                  cmd_d  = CMD_RESP;
                  resp_d = (hold_q == CMD_READ) ? pins_s : hold_q;
               end
            end
         end
         CMD_WAIT_DATA: begin
            if (hold_full_q) begin
               out_d  = hold_q;
               resp_d = RESP_ACK;
               cmd_d  = CMD_RESP;
            end
         end
         CMD_RESP: begin
            if (tx_accept) cmd_d = CMD_IDLE;
         end
         default: cmd_d = CMD_IDLE;
      endcase
      rts_d = !hold_full_d && (cmd_d == CMD_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cmd_q       <= CMD_IDLE;
         resp_q      <= '0;
         out_q       <= '0;
         rts_q       <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cmd_q       <= cmd_d;
         resp_q      <= resp_d;
         out_q       <= out_d;
         rts_q       <= rts_d;
      end
   end

   // ------------------------------------------------------------ transmitter
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic       txd_q, txd_d;
   logic       n_tx_en_q, n_tx_en_d;
   logic       tx_restart, tx_bit;
`ifdef ANACRON_PARITY_EN
   logic       tx_par_q, tx_par_d;
`endif

   anacron_uart_bitclk #(.BIT_DIV(BIT_DIV)) u_tx_bitclk (
      .clk       (clk),
      .rst       (rst),
      .restart_i (tx_restart),
      .mid_o     (),
      .bit_o     (tx_bit)
   );

   always_comb begin
      tx_phase_d = tx_phase_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      txd_d      = txd_q;
      n_tx_en_d  = n_tx_en_q;
      tx_restart = 1'b0;
`ifdef ANACRON_PARITY_EN
      tx_par_d = tx_par_q;
`endif
      case (tx_phase_q)
         PH_IDLE: begin
            if (tx_accept) begin
               tx_phase_d = PH_LEAD;
               tx_sh_d    = resp_q;
               n_tx_en_d  = 1'b0;
`ifdef ANACRON_PARITY_EN
               tx_par_d = even_parity(resp_q);
`endif
            end
         end
         PH_LEAD: begin
            tx_phase_d = PH_START;
            txd_d      = 1'b0;
            tx_restart = 1'b1;
         end
         PH_START: begin
            if (tx_bit) begin
               txd_d      = tx_sh_q[0];
               tx_sh_d    = {1'b0, tx_sh_q[7:1]};
               tx_bit_d   = 3'd0;
               tx_phase_d = PH_DATA;
            end
         end
         PH_DATA: begin
            if (tx_bit) begin
               if (tx_bit_q == 3'd7) begin
`ifdef ANACRON_PARITY_EN
                  txd_d      = tx_par_q;
                  tx_phase_d = PH_PARITY;
`else
                  txd_d      = 1'b1;
                  tx_phase_d = PH_STOP;
`endif
               end else begin
                  txd_d    = tx_sh_q[0];
                  tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
         end
`ifdef ANACRON_PARITY_EN
         PH_PARITY: begin
            if (tx_bit) begin
               txd_d      = 1'b1;
               tx_phase_d = PH_STOP;
            end
         end
`endif
         PH_STOP: begin
            if (tx_bit) tx_phase_d = PH_TAIL;
         end
         PH_TAIL: begin
            n_tx_en_d  = 1'b1;
            tx_phase_d = PH_IDLE;
         end
         default: begin
            tx_phase_d = PH_IDLE;
            txd_d      = 1'b1;
            n_tx_en_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_phase_q <= PH_IDLE;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         txd_q      <= 1'b1;
         n_tx_en_q  <= 1'b1;
`ifdef ANACRON_PARITY_EN
         tx_par_q <= 1'b0;
`endif
      end else begin
         tx_phase_q <= tx_phase_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         txd_q      <= txd_d;
         n_tx_en_q  <= n_tx_en_d;
`ifdef ANACRON_PARITY_EN
         tx_par_q <= tx_par_d;
`endif
      end
   end

   assign output_pins = out_q;
   assign txd         = txd_q;
   assign rts         = rts_q;
   assign n_tx_en     = n_tx_en_q;

endmodule

`default_nettype wire

// File: tb/tb_anacron_io_top.sv
// ============================================================================
// tb_anacron_io_top : directed self-checking bench for anacron_io_top (BIT_DIV=8).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_anacron_io_top;

   localparam int BIT_DIV = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] input_pins;
   logic [7:0] output_pins;
   logic       rxd;
   logic       txd;
   logic       cts;
   logic       rts;
   logic       n_tx_en;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   anacron_io_top #(.BIT_DIV(BIT_DIV), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .input_pins  (input_pins),
      .output_pins (output_pins),
      .rxd         (rxd),
      .txd         (txd),
      .cts         (cts),
      .rts         (rts),
      .n_tx_en     (n_tx_en)
   );

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one frame on rxd followed by one idle bit time.
   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rxd = 1'b0;
      repeat (BIT_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT_DIV) @(negedge clk);
      end
`ifdef ANACRON_PARITY_EN
      rxd = ^b;
      repeat (BIT_DIV) @(negedge clk);
`endif
      rxd = stop_bit;
      repeat (BIT_DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT_DIV) @(negedge clk);
   endtask

   // Waits for a start bit on txd and samples the frame mid-bit.
   task automatic uart_capture(output logic [7:0] data, output logic seen,
                               output logic en_ok, output logic stop_ok,
                               output logic en_after);
      int n;
      data = '0; seen = 1'b0; en_ok = 1'b1; stop_ok = 1'b0; en_after = 1'b0;
      n = 0;
      while (txd !== 1'b0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (txd !== 1'b0) return;
      seen = 1'b1;
      if (n_tx_en !== 1'b0) en_ok = 1'b0;
      repeat (BIT_DIV / 2) @(negedge clk);
      if (txd !== 1'b0 || n_tx_en !== 1'b0) en_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (BIT_DIV) @(negedge clk);
         data[i] = txd;
         if (n_tx_en !== 1'b0) en_ok = 1'b0;
      end
`ifdef ANACRON_PARITY_EN
      repeat (BIT_DIV) @(negedge clk);
      if (n_tx_en !== 1'b0) en_ok = 1'b0;
`endif
      repeat (BIT_DIV) @(negedge clk);
      stop_ok = (txd === 1'b1);
      if (n_tx_en !== 1'b0) en_ok = 1'b0;
      // Last cycle of the stop bit, then the driver enable releases.
      repeat (BIT_DIV / 2) @(negedge clk);
      if (n_tx_en !== 1'b0) en_ok = 1'b0;
      @(negedge clk);
      en_after = (n_tx_en === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; rxd = 1'b1; cts = 1'b1; input_pins = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (rts !== 1'b0) $display("FAIL reset_rts: got %b expected 0", rts); else passed++;
      checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else passed++;
      checks++; if (n_tx_en !== 1'b1) $display("FAIL reset_ntxen: got %b expected 1", n_tx_en); else passed++;
      checks++; if (output_pins !== 8'h00) $display("FAIL reset_out: got %h expected 00", output_pins); else passed++;
      rst = 1'b0;
      repeat (20 * BIT_DIV) @(negedge clk);
      checks++; if (rts !== 1'b1) $display("FAIL idle_rts: got %b expected 1", rts); else passed++;
      checks++; if (txd !== 1'b1) $display("FAIL idle_txd: got %b expected 1", txd); else passed++;
      checks++; if (n_tx_en !== 1'b1) $display("FAIL idle_ntxen: got %b expected 1", n_tx_en); else passed++;
      checks++; if (output_pins !== 8'h00) $display("FAIL idle_out: got %h expected 00", output_pins); else passed++;
   endtask

   task automatic test_write();
      logic [7:0] d;
      logic seen, en_ok, stop_ok, en_after;
      fork
         begin
            uart_send(8'h01, 1'b1);
            uart_send(8'hA5, 1'b1);
         end
         uart_capture(d, seen, en_ok, stop_ok, en_after);
      join
      checks++; if (seen !== 1'b1) $display("FAIL write_seen: got %b expected 1", seen); else passed++;
      checks++; if (d !== 8'h01) $display("FAIL write_ack: got %h expected 01", d); else passed++;
      checks++; if (en_ok !== 1'b1) $display("FAIL write_ntxen_low: got %b expected 1", en_ok); else passed++;
      checks++; if (stop_ok !== 1'b1) $display("FAIL write_stop: got %b expected 1", stop_ok); else passed++;
      checks++; if (en_after !== 1'b1) $display("FAIL write_ntxen_release: got %b expected 1", en_after); else passed++;
      checks++; if (output_pins !== 8'hA5) $display("FAIL write_out: got %h expected a5", output_pins); else passed++;
      checks++; if (rts !== 1'b1) $display("FAIL write_rts: got %b expected 1", rts); else passed++;
   endtask

   task automatic test_read(input logic [7:0] pins);
      logic [7:0] d;
      logic seen, en_ok, stop_ok, en_after;
      input_pins = pins;
      repeat (4) @(negedge clk);
      fork
         uart_send(8'h02, 1'b1);
         uart_capture(d, seen, en_ok, stop_ok, en_after);
      join
      checks++; if (seen !== 1'b1) $display("FAIL read_seen: got %b expected 1", seen); else passed++;
      checks++; if (d !== pins) $display("FAIL read_data: got %h expected %h", d, pins); else passed++;
   endtask

   task automatic test_cts();
      logic [7:0] d;
      logic seen, en_ok, stop_ok, en_after;
      logic quiet;
      cts = 1'b0;
      repeat (4) @(negedge clk);
      uart_send(8'h55, 1'b1);
      quiet = 1'b1;
      for (int i = 0; i < 20 * BIT_DIV; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || n_tx_en !== 1'b1) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) $display("FAIL cts_hold_quiet: got %b expected 1", quiet); else passed++;
      checks++; if (rts !== 1'b0) $display("FAIL cts_hold_rts: got %b expected 0", rts); else passed++;
      cts = 1'b1;
      uart_capture(d, seen, en_ok, stop_ok, en_after);
      checks++; if (seen !== 1'b1) $display("FAIL cts_seen: got %b expected 1", seen); else passed++;
      checks++; if (d !== 8'h55) $display("FAIL cts_echo: got %h expected 55", d); else passed++;
   endtask

   task automatic test_framing();
      logic [7:0] d;
      logic seen, en_ok, stop_ok, en_after;
      logic quiet;
      uart_send(8'h7E, 1'b0);
      quiet = 1'b1;
      for (int i = 0; i < 20 * BIT_DIV; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || n_tx_en !== 1'b1) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) $display("FAIL frame_err_quiet: got %b expected 1", quiet); else passed++;
      checks++; if (output_pins !== 8'hA5) $display("FAIL frame_err_out: got %h expected a5", output_pins); else passed++;
      fork
         uart_send(8'h41, 1'b1);
         uart_capture(d, seen, en_ok, stop_ok, en_after);
      join
      checks++; if (seen !== 1'b1) $display("FAIL frame_next_seen: got %b expected 1", seen); else passed++;
      checks++; if (d !== 8'h41) $display("FAIL frame_next_echo: got %h expected 41", d); else passed++;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      logic seen, en_ok, stop_ok, en_after;
      int n;
      uart_send(8'h33, 1'b1);
      n = 0;
      while (txd !== 1'b0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (txd !== 1'b0) $display("FAIL rstmid_start: got %b expected 0", txd); else passed++;
      repeat (3 * BIT_DIV) @(negedge clk);
      checks++; if (n_tx_en !== 1'b0) $display("FAIL rstmid_inframe_ntxen: got %b expected 0", n_tx_en); else passed++;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (txd !== 1'b1) $display("FAIL rstmid_txd: got %b expected 1", txd); else passed++;
      checks++; if (n_tx_en !== 1'b1) $display("FAIL rstmid_ntxen: got %b expected 1", n_tx_en); else passed++;
      checks++; if (output_pins !== 8'h00) $display("FAIL rstmid_out: got %h expected 00", output_pins); else passed++;
      checks++; if (rts !== 1'b0) $display("FAIL rstmid_rts: got %b expected 0", rts); else passed++;
      rst = 1'b0;
      repeat (2 * BIT_DIV) @(negedge clk);
      checks++; if (rts !== 1'b1) $display("FAIL rstmid_rts_release: got %b expected 1", rts); else passed++;
      fork
         uart_send(8'h02, 1'b1);
         uart_capture(d, seen, en_ok, stop_ok, en_after);
      join
      checks++; if (seen !== 1'b1) $display("FAIL rstmid_after_seen: got %b expected 1", seen); else passed++;
      checks++; if (d !== 8'hC3) $display("FAIL rstmid_after_read: got %h expected c3", d); else passed++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read(8'h3C);
      test_read(8'hC3);
      test_cts();
      test_framing();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
